// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sequencer that shares one external combinational
// ALU between two valid/ready requesters and returns tagged results.
// Optional grant statistics are built when ALU_REQ_ARBITER_STATS_EN is defined;
// otherwise stat_cnt0/stat_cnt1 are tied to zero and the port list is unchanged.
module alu_req_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [15:0]      stat_cnt0,
    output logic [15:0]      stat_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   gnt_id;
    logic   accept;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt_id = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_grant;
        end
    end

    // Next-state decode and ready generation; readies only ever assert in IDLE.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, result capture and response handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (accept) begin
                alu_a      <= gnt_id ? req1_a  : req0_a;
                alu_b      <= gnt_id ? req1_b  : req0_b;
                alu_op     <= gnt_id ? req1_op : req0_op;
                rsp_id     <= gnt_id;
                last_grant <= gnt_id;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_res;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef ALU_REQ_ARBITER_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (!gnt_id && cnt0 != '1) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (gnt_id && cnt1 != '1) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end

    assign stat_cnt0 = cnt0;
    assign stat_cnt1 = cnt1;
`else
    assign stat_cnt0 = '0;
    assign stat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed + randomized bench for alu_req_arbiter with a behavioural ALU and a
// transaction-level reference model (grant rule, expected result, grant counts).
module tb_alu_req_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [2:0] alu_op;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;
    logic [15:0] stat_cnt0, stat_cnt1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit         m_last = 1'b1;
    int         m_cnt0 = 0;
    int         m_cnt1 = 0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [2:0] m_op = '0;

    alu_req_arbiter #(.WIDTH(8), .OPW(3)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return 8'((int'(a) + int'(b)) % 256);
            3'b001:  return 8'((int'(a) - int'(b) + 256) % 256);
            3'b010:  return 8'((int'(a) * (1 << b[2:0])) % 256);
            3'b011:  return 8'(int'(a) / (1 << b[2:0]));
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return (a == b) ? 8'd1 : 8'd0;
        endcase
    endfunction

    // Shared ALU living outside the block
    always_comb alu_res = alu_f(alu_a, alu_b, alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef ALU_REQ_ARBITER_STATS_EN
        chk("stat_cnt0", {16'd0, stat_cnt0}, m_cnt0);
        chk("stat_cnt1", {16'd0, stat_cnt1}, m_cnt1);
`else
        chk("stat_cnt0", {16'd0, stat_cnt0}, 0);
        chk("stat_cnt1", {16'd0, stat_cnt1}, 0);
`endif
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        m_a = '0; m_b = '0; m_op = '0;
    endtask

    task automatic scramble_inputs();
        req0_valid = 1'($urandom); req1_valid = 1'($urandom);
        req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 3'($urandom);
        req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 3'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        model_reset();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk_stats();
        rst = 1'b0;
    endtask

    // One full transaction starting in IDLE just after a falling edge.
    // expc / expid < 0 means no directed constant to compare against.
    task automatic txn(input bit v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] o0,
                       input bit v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] o1,
                       input int unsigned hold, input int expc, input int expid);
        bit g;
        logic [7:0] er;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
        rsp_ready = 1'b0;
        #1;
        g = (v0 && v1) ? !m_last : v1;
        chk("idle_busy", busy, 0);
        chk("grant_ready0", req0_ready, !g);
        chk("grant_ready1", req1_ready, g);
        m_a = g ? a1 : a0; m_b = g ? b1 : b0; m_op = g ? o1 : o0;
        er = alu_f(m_a, m_b, m_op);
        @(posedge clk);
        m_last = g;
        if (g) begin
            if (m_cnt1 < 65535) m_cnt1++;
        end else begin
            if (m_cnt0 < 65535) m_cnt0++;
        end
        @(negedge clk);
        scramble_inputs();
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_alu_a", alu_a, m_a);
        chk("exec_alu_b", alu_b, m_b);
        chk("exec_alu_op", alu_op, m_op);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_ready", {req1_ready, req0_ready}, 0);
        @(posedge clk); @(negedge clk);
        scramble_inputs();
        #1;
        chk("resp_valid", rsp_valid, 1);
        chk("resp_data", rsp_data, er);
        chk("resp_id", rsp_id, g);
        chk("resp_ready", {req1_ready, req0_ready}, 0);
        if (expc >= 0) chk("resp_data_const", rsp_data, expc);
        if (expid >= 0) chk("resp_id_const", rsp_id, expid);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            scramble_inputs();
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, er);
            chk("hold_id", rsp_id, g);
            chk("hold_busy", busy, 1);
            chk("hold_ready", {req1_ready, req0_ready}, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_alu_hold", {alu_op, alu_b, alu_a}, {m_op, m_b, m_a});
        chk_stats();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit v0, v1;
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        @(negedge clk);
        do_reset();

        // Basic op
        txn(1, 8'd20, 8'd15, 3'b000, 0, 8'd0, 8'd0, 3'b000, 0, 35, 0);

        // Tie and round-robin from reset
        do_reset();
        txn(1, 8'd20, 8'd15, 3'b001, 1, 8'd20, 8'd15, 3'b110, 0, 5, 0);
        txn(1, 8'd20, 8'd15, 3'b001, 1, 8'd20, 8'd15, 3'b110, 0, 27, 1);
        txn(1, 8'd20, 8'd15, 3'b001, 1, 8'd20, 8'd15, 3'b110, 0, 5, 0);

        // Backpressure
        txn(1, 8'd9, 8'd3, 3'b100, 0, 8'd0, 8'd0, 3'b000, 5, 1, 0);

        // Wrap and pass-through
        txn(0, 8'd0, 8'd0, 3'b000, 1, 8'd200, 8'd100, 3'b000, 0, 44, 1);
        txn(0, 8'd0, 8'd0, 3'b000, 1, 8'h81, 8'd1, 3'b011, 0, 8'h40, 1);
        txn(0, 8'd0, 8'd0, 3'b000, 1, 8'd7, 8'd7, 3'b111, 0, 1, 1);

        // Reset during EXEC abandons the operation
        req0_valid = 1'b1; req0_a = 8'd55; req0_b = 8'd66; req0_op = 3'b101;
        @(posedge clk); @(negedge clk);
        #1;
        chk("midrst_exec_busy", busy, 1);
        rst = 1'b1; req0_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        model_reset();
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_alu", {alu_op, alu_b, alu_a}, 0);
        chk_stats();
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("midrst_after_valid", rsp_valid, 0);
        chk("midrst_after_busy", busy, 0);
        txn(1, 8'd10, 8'd4, 3'b010, 1, 8'd1, 8'd2, 3'b000, 0, 8'd160, 0);

        // Stats: 3 req0 ops and 2 req1 ops after reset
        do_reset();
        txn(1, 8'd1, 8'd1, 3'b000, 0, 8'd0, 8'd0, 3'b000, 0, 2, 0);
        txn(0, 8'd0, 8'd0, 3'b000, 1, 8'd3, 8'd1, 3'b001, 0, 2, 1);
        txn(1, 8'd5, 8'd3, 3'b101, 1, 8'd5, 8'd3, 3'b100, 0, 7, 0);
        txn(0, 8'd0, 8'd0, 3'b000, 1, 8'hF0, 8'h0F, 3'b110, 1, 8'hFF, 1);
        txn(1, 8'd4, 8'd5, 3'b111, 0, 8'd0, 8'd0, 3'b000, 0, 0, 0);
`ifdef ALU_REQ_ARBITER_STATS_EN
        chk("stats_const0", {16'd0, stat_cnt0}, 3);
        chk("stats_const1", {16'd0, stat_cnt1}, 2);
`else
        chk("stats_const0", {16'd0, stat_cnt0}, 0);
        chk("stats_const1", {16'd0, stat_cnt1}, 0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            txn(v0, 8'($urandom), 8'($urandom), 3'($urandom),
                v1, 8'($urandom), 8'($urandom), 3'($urandom),
                $urandom_range(0, 3), -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Sequencing controller and arbiter that shares one combinational 8-bit ALU between two requesters.
- Each requester presents operands and an opcode over a valid/ready handshake.
- The block grants access round-robin, drives the ALU inputs from registered operands, captures the result, and returns it with the requester ID over a valid/ready response channel.
- Sits between client engines and the shared ALU instance; the ALU itself stays outside this block.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 3, opcode width in bits; the opcode is passed through unmodified to the ALU.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 handshake accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand A.
- req0_b  in  WIDTH  requester 0 operand B.
- req0_op  in  OPW  requester 0 opcode.
- req1_valid / req1_ready / req1_a / req1_b / req1_op: same as requester 0, for requester 1.
- alu_a  out  WIDTH  to shared ALU operand A.
- alu_b  out  WIDTH  to shared ALU operand B.
- alu_op  out  OPW  to shared ALU opcode.
- alu_res  in  WIDTH  combinational result from the shared ALU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_id  out  1  requester that issued the operation.
- busy  out  1  high in any state other than IDLE.
- stat_cnt0  out  16  grants to requester 0 (see Optional Feature).
- stat_cnt1  out  16  grants to requester 1 (see Optional Feature).

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - alu_a, alu_b, alu_op = 0.
  - rsp_valid, rsp_data, rsp_id, busy = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - stat counters = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one valid -> that requester. Both valid -> the requester != last_grant.
  - reqN_ready = 1 only for the granted requester, only in IDLE. All ready outputs are 0 in every other state.
  - On handshake at edge k: latch a/b/op into the alu_a/alu_b/alu_op registers, latch the ID into rsp_id, set last_grant = ID, go to EXEC.
- EXEC:
  - Lasts exactly one cycle; alu_* hold the latched operands.
  - At edge k+1: rsp_data <= alu_res, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready = 1.
  - On handshake: rsp_valid <= 0, go to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake.
- Timing:
  - Latency from request handshake to rsp_valid = 1 is one cycle.
  - Peak throughput is one op per 3 cycles.
- Holding: alu_* outputs keep their last operands in IDLE. No combinational path from req* to alu_*.
- Arithmetic: the block performs none; wrap-around and width behaviour belong to the ALU, and the result is captured verbatim.
- Mid-operation changes:
  - A valid that drops while not granted is legal and is simply ignored.
  - Requester inputs changing after acceptance do not affect the in-flight operation.
- rst in any state abandons the in-flight operation. No response is emitted, and all registers return to reset values on that edge.
- ALU opcode map used by the benches: 000 add, 001 sub, 010 sll (by b[2:0]), 011 srl (by b[2:0]), 100 and, 101 or, 110 xor, 111 eq (1 if a==b else 0).

Optional Feature:
- Macro ALU_REQ_ARBITER_STATS_EN.
- Defined:
  - stat_cnt0 and stat_cnt1 each increment by 1 on every request handshake of their requester.
  - Each counter saturates at 16'hFFFF and clears on rst.
- Undefined: no counter registers are built; stat_cnt0 and stat_cnt1 are tied to 0. The port list is identical in both builds.

Test Plan:
- Basic op: after reset, req0 a=20 b=15 op=000, rsp_ready=1 -> req0_ready high at acceptance; rsp_valid one cycle later with rsp_data=35, rsp_id=0.
- Tie and round-robin: req0 (20,15,op=001) and req1 (20,15,op=110) both valid from reset -> req0 first, rsp_data=5 id=0. Then req1, rsp_data=27 id=1. Re-issue both: req0 wins again (last_grant=1).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable and req0_ready=req1_ready=0 throughout. On rsp_ready=1 the handshake completes and IDLE is entered the next cycle.
- Wrap and pass-through: req1 a=200 b=100 op=000 -> rsp_data=44. Then a=8'h81 b=1 op=011 -> rsp_data=8'h40. Then a=7 b=7 op=111 -> rsp_data=1.
- Reset mid-op: accept a req0 op, assert rst during EXEC -> rsp_valid never rises, busy=0, alu_*=0 after the edge. The next request after rst deasserts completes normally.
- Stats (macro defined): 3 req0 ops and 2 req1 ops -> stat_cnt0=3, stat_cnt1=2. With the macro undefined, both stay 0.
